// File: rtl/cpu_step_disp_pkg.sv
// ============================================================================
// cpu_step_disp_pkg : shared FSM encoding and seven-segment constants
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_step_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DIG_W     = 3;
  localparam int         TMO_W     = 8;

  // Active-low g..a patterns for 0-9, A, b, C, d, E, F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/cpu_step_disp_hex_to_seg7.sv
// ============================================================================
// hex_to_seg7 : 4-bit nibble to active-low seven-segment pattern (g..a)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module hex_to_seg7
  import cpu_step_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

`default_nettype wire

// File: rtl/cpu_step_disp.sv
// ============================================================================
// cpu_step_disp : single-step controller with 8-digit multiplexed debug display
// Optional: define STEP_CNT_EN to build the step counter shown on digits 7..6.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cpu_step_disp
  import cpu_step_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  key_v,
  input  logic        cpu_done,
  input  logic [15:0] dbg_word,
  output logic        cpu_step,
  output logic [2:0]  dbg_sel,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int               PRE_W    = $clog2(SCAN_DIV);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  state_t             r_state;
  state_t             w_next;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_err;
  logic [15:0]        r_word;
  logic               r_step;
  logic               r_busy;
  logic [2:0]         r_sel;
  logic               w_tmo_hit;

  assign w_tmo_hit = (r_state == ST_WAIT) && !cpu_done && (r_tmo == TMO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_STEP;
      ST_STEP:  w_next = ST_WAIT;
      ST_WAIT:  if (cpu_done || w_tmo_hit) w_next = ST_LATCH;
      ST_LATCH: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Step enable and busy are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_sel   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      r_step  <= (w_next == ST_STEP);
      r_busy  <= (w_next != ST_IDLE);
      r_sel   <= key_v;
      case (r_state)
        ST_IDLE: begin
          r_word <= dbg_word;
          if (start) r_err <= 1'b0;
        end
        ST_STEP: r_tmo <= '0;
        ST_WAIT: begin
          if (!cpu_done) r_tmo <= r_tmo + TMO_W'(1);
          if (w_tmo_hit) r_err <= 1'b1;
        end
        ST_LATCH: r_word <= dbg_word;
        default: ;
      endcase
    end
  end

  assign cpu_step = r_step;
  assign busy     = r_busy;
  assign dbg_sel  = r_sel;

`ifdef STEP_CNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_cnt <= '0;
    else if (r_state == ST_LATCH) r_cnt <= r_cnt + 8'd1;
  end
`endif

  // Display scan: segment data is computed for the digit about to be enabled.
  logic [PRE_W-1:0] r_pre;
  logic [DIG_W-1:0] r_dig;
  logic [DIG_W-1:0] w_dig_nxt;
  logic             w_wrap;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic             w_dp_n;
  logic [6:0]       w_pat;
  logic [7:0]       w_seg_nxt;

  assign w_wrap    = (r_pre == PRE_LAST);
  assign w_dig_nxt = r_dig + DIG_W'(1);

  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    w_dp_n  = 1'b1;
    case (w_dig_nxt)
      3'd0: begin
        w_nib  = r_word[3:0];
        w_dp_n = ~r_err;
      end
      3'd1: w_nib = r_word[7:4];
      3'd2: w_nib = r_word[11:8];
      3'd3: w_nib = r_word[15:12];
      3'd4: w_blank = 1'b1;
      3'd5: w_nib = {1'b0, r_sel};
`ifdef STEP_CNT_EN
      3'd6: w_nib = r_cnt[3:0];
      3'd7: w_nib = r_cnt[7:4];
`else
      3'd6: w_blank = 1'b1;
      3'd7: w_blank = 1'b1;
`endif
      default: w_blank = 1'b1;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nib (w_nib),
    .seg (w_pat)
  );

  assign w_seg_nxt = w_blank ? SEG_BLANK : {w_dp_n, w_pat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_dig <= '0;
      an    <= 8'hFF;
      seg   <= SEG_BLANK;
    end else if (w_wrap) begin
      r_pre <= '0;
      r_dig <= w_dig_nxt;
      an    <= ~(8'b1 << w_dig_nxt);
      seg   <= w_seg_nxt;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_disp.sv
// ============================================================================
// tb_cpu_step_disp : directed self-checking bench for cpu_step_disp
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_disp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  key_v;
  logic        cpu_done;
  logic [15:0] dbg_word;
  logic        cpu_step;
  logic [2:0]  dbg_sel;
  logic        busy;
  logic [7:0]  seg;
  logic [7:0]  an;

  int         n_checks    = 0;
  int         n_pass      = 0;
  int         step_pulses = 0;
  logic [7:0] exp_cnt     = 8'd0;

  cpu_step_disp #(.SCAN_DIV(2), .DONE_TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_v    (key_v),
    .cpu_done (cpu_done),
    .dbg_word (dbg_word),
    .cpu_step (cpu_step),
    .dbg_sel  (dbg_sel),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cpu_step === 1'b1) step_pulses++;

  // Expected digit pattern built from active-high segment codes.
  function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp_lit);
    logic [6:0] hi;
    case (n)
      4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
      4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
      4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
      4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
    endcase
    return {~dp_lit, ~hi};
  endfunction

  function automatic logic [7:0] exp_cnt_dig(input int k);
`ifdef STEP_CNT_EN
    return seg_of((k == 6) ? exp_cnt[3:0] : exp_cnt[7:4], 1'b0);
`else
    return (k >= 0) ? 8'hFF : 8'h00;
`endif
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for a fresh slot of digit k so the pattern reflects current state.
  task automatic read_digit(input int k, output logic [7:0] s);
    logic [7:0] tgt;
    int t;
    tgt = ~(8'b1 << k);
    t = 0;
    while (an === tgt && t < 40) begin tick(); t++; end
    t = 0;
    while (an !== tgt && t < 40) begin tick(); t++; end
    if (an !== tgt) begin
      n_checks++;
      $display("FAIL scan_timeout digit %0d an=%h want %h", k, an, tgt);
    end
    s = seg;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy === 1'b1 && t < 30) begin tick(); t++; end
    if (busy !== 1'b0) begin
      n_checks++;
      $display("FAIL %s_idle_timeout busy=%b want 0", tag, busy);
    end
  endtask

  task automatic do_fast_step();
    cpu_done = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("fast");
    cpu_done = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    logic [7:0] s;
    int p0;
    rst = 1'b1; start = 1'b0; cpu_done = 1'b0; key_v = 3'd0; dbg_word = 16'h0000;
    tick(3);
    n_checks++; if (cpu_step !== 1'b0) $display("FAIL rst_step got %b want 0", cpu_step); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (an !== 8'hFF) $display("FAIL rst_an got %h want ff", an); else n_pass++;
    n_checks++; if (seg !== 8'hFF) $display("FAIL rst_seg got %h want ff", seg); else n_pass++;
    n_checks++; if (dbg_sel !== 3'd0) $display("FAIL rst_sel got %0d want 0", dbg_sel); else n_pass++;
    rst = 1'b0;
    tick(2);
    // Reset asserted while waiting for done
    start = 1'b1; tick(); start = 1'b0;
    tick(2);
    n_checks++; if (busy !== 1'b1) $display("FAIL midwait_busy got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (cpu_step !== 1'b0) $display("FAIL midrst_step got %b want 0", cpu_step); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (an !== 8'hFF) $display("FAIL midrst_an got %h want ff", an); else n_pass++;
    n_checks++; if (seg !== 8'hFF) $display("FAIL midrst_seg got %h want ff", seg); else n_pass++;
    p0 = step_pulses;
    tick(2);
    rst = 1'b0;
    tick(6);
    n_checks++; if (step_pulses != p0) $display("FAIL midrst_extra_step got %0d want %0d", step_pulses, p0); else n_pass++;
    exp_cnt = 8'd0;
    read_digit(6, s);
    n_checks++; if (s !== exp_cnt_dig(6)) $display("FAIL rst_cnt_d6 got %h want %h", s, exp_cnt_dig(6)); else n_pass++;
    read_digit(7, s);
    n_checks++; if (s !== exp_cnt_dig(7)) $display("FAIL rst_cnt_d7 got %h want %h", s, exp_cnt_dig(7)); else n_pass++;
  endtask

  task automatic test_key_lag();
    key_v = 3'd2; tick(2);
    key_v = 3'd6; #1;
    n_checks++; if (dbg_sel !== 3'd2) $display("FAIL sel_lag_before got %0d want 2", dbg_sel); else n_pass++;
    tick();
    n_checks++; if (dbg_sel !== 3'd6) $display("FAIL sel_lag_after got %0d want 6", dbg_sel); else n_pass++;
  endtask

  task automatic test_normal_step();
    logic [7:0] s;
    logic [15:0] w;
    int p0;
    key_v = 3'd3; dbg_word = 16'hA5C3; w = 16'hA5C3;
    tick(3);
    p0 = step_pulses;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (cpu_step !== 1'b1) $display("FAIL norm_step got %b want 1", cpu_step); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL norm_busy got %b want 1", busy); else n_pass++;
    n_checks++; if (dbg_sel !== 3'd3) $display("FAIL norm_sel got %0d want 3", dbg_sel); else n_pass++;
    tick();
    n_checks++; if (cpu_step !== 1'b0) $display("FAIL norm_step_once got %b want 0", cpu_step); else n_pass++;
    tick(2);
    cpu_done = 1'b1; tick(); cpu_done = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL norm_latch_busy got %b want 1", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL norm_idle_busy got %b want 0", busy); else n_pass++;
    exp_cnt = exp_cnt + 8'd1;
    tick(2);
    n_checks++; if (step_pulses - p0 != 1) $display("FAIL norm_pulses got %0d want 1", step_pulses - p0); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] nib;
      nib = w[4*k +: 4];
      read_digit(k, s);
      n_checks++; if (s !== seg_of(nib, 1'b0)) $display("FAIL norm_digit%0d got %h want %h", k, s, seg_of(nib, 1'b0)); else n_pass++;
    end
    read_digit(5, s);
    n_checks++; if (s !== seg_of(4'h3, 1'b0)) $display("FAIL norm_sel_digit got %h want %h", s, seg_of(4'h3, 1'b0)); else n_pass++;
    read_digit(6, s);
    n_checks++; if (s !== exp_cnt_dig(6)) $display("FAIL norm_cnt_d6 got %h want %h", s, exp_cnt_dig(6)); else n_pass++;
    read_digit(7, s);
    n_checks++; if (s !== exp_cnt_dig(7)) $display("FAIL norm_cnt_d7 got %h want %h", s, exp_cnt_dig(7)); else n_pass++;
  endtask

  task automatic test_busy_reject();
    logic [7:0] s;
    int p0;
    p0 = step_pulses;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    cpu_done = 1'b1; tick(); cpu_done = 1'b0;
    wait_idle("reject");
    exp_cnt = exp_cnt + 8'd1;
    tick(3);
    n_checks++; if (step_pulses - p0 != 1) $display("FAIL reject_pulses got %0d want 1", step_pulses - p0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reject_queued busy got %b want 0", busy); else n_pass++;
    read_digit(6, s);
    n_checks++; if (s !== exp_cnt_dig(6)) $display("FAIL reject_cnt_d6 got %h want %h", s, exp_cnt_dig(6)); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [7:0] s;
    int b;
    start = 1'b1; tick(); start = 1'b0;
    b = 1;
    while (busy === 1'b1 && b < 20) begin
      tick();
      if (busy === 1'b1) b++;
    end
    n_checks++; if (b != 6) $display("FAIL tmo_busy_cycles got %0d want 6", b); else n_pass++;
    exp_cnt = exp_cnt + 8'd1;
    read_digit(0, s);
    n_checks++; if (s !== seg_of(4'h3, 1'b1)) $display("FAIL tmo_dp_lit got %h want %h", s, seg_of(4'h3, 1'b1)); else n_pass++;
    read_digit(1, s);
    n_checks++; if (s[7] !== 1'b1) $display("FAIL tmo_dp_other got %b want 1", s[7]); else n_pass++;
    // Done arriving on the final WAIT cycle completes normally and start clears err.
    start = 1'b1; tick(); start = 1'b0;
    tick(4);
    cpu_done = 1'b1; tick(); cpu_done = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL tmo_edge_latch busy got %b want 1", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL tmo_edge_idle busy got %b want 0", busy); else n_pass++;
    exp_cnt = exp_cnt + 8'd1;
    read_digit(0, s);
    n_checks++; if (s !== seg_of(4'h3, 1'b0)) $display("FAIL tmo_err_clear got %h want %h", s, seg_of(4'h3, 1'b0)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    cpu_done = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n = 1;
    while (busy === 1'b1 && n < 20) begin tick(); n++; end
    n_checks++; if (n != 4) $display("FAIL b2b_latency got %0d want 4", n); else n_pass++;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (cpu_step !== 1'b1) $display("FAIL b2b_accept got %b want 1", cpu_step); else n_pass++;
    wait_idle("b2b");
    cpu_done = 1'b0;
    exp_cnt = exp_cnt + 8'd2;
  endtask

  task automatic test_wrap();
    logic [7:0] s;
    while (exp_cnt != 8'd255) do_fast_step();
    read_digit(6, s);
    n_checks++; if (s !== exp_cnt_dig(6)) $display("FAIL wrap255_d6 got %h want %h", s, exp_cnt_dig(6)); else n_pass++;
    read_digit(7, s);
    n_checks++; if (s !== exp_cnt_dig(7)) $display("FAIL wrap255_d7 got %h want %h", s, exp_cnt_dig(7)); else n_pass++;
    do_fast_step();
    read_digit(6, s);
    n_checks++; if (s !== exp_cnt_dig(6)) $display("FAIL wrap0_d6 got %h want %h", s, exp_cnt_dig(6)); else n_pass++;
    read_digit(7, s);
    n_checks++; if (s !== exp_cnt_dig(7)) $display("FAIL wrap0_d7 got %h want %h", s, exp_cnt_dig(7)); else n_pass++;
  endtask

  task automatic test_scan();
    logic [7:0] s;
    logic [7:0] prev;
    logic [7:0] want;
    int idx;
    int t;
    key_v = 3'd5;
    tick(2);
    prev = an; t = 0;
    while (an === prev && t < 10) begin tick(); t++; end
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] oh;
      oh = ~(8'b1 << i);
      if (an === oh) idx = i;
    end
    n_checks++; if (idx < 0) $display("FAIL scan_onehot got %h want one-hot-low", an); else n_pass++;
    if (idx < 0) idx = 0;
    for (int sl = 0; sl < 16; sl++) begin
      prev = an;
      tick();
      n_checks++; if (an !== prev) $display("FAIL scan_hold slot %0d got %h want %h", sl, an, prev); else n_pass++;
      tick();
      idx = (idx + 1) % 8;
      want = ~(8'b1 << idx);
      n_checks++; if (an !== want) $display("FAIL scan_step slot %0d got %h want %h", sl, an, want); else n_pass++;
    end
    read_digit(4, s);
    n_checks++; if (s !== 8'hFF) $display("FAIL scan_blank_d4 got %h want ff", s); else n_pass++;
    read_digit(5, s);
    n_checks++; if (s !== seg_of(4'h5, 1'b0)) $display("FAIL scan_sel_d5 got %h want %h", s, seg_of(4'h5, 1'b0)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_key_lag();
    test_normal_step();
    test_busy_reject();
    test_timeout();
    test_back_to_back();
    test_wrap();
    test_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_step_disp.md
# cpu_step_disp

Single-step and debug-display controller for the simple processor board build. Consumes the one-cycle `start` pulse and the 3-bit view selector `key_v` produced by the button front end, issues one CPU step per `start`, selects which CPU debug word to view, and drives an 8-digit multiplexed seven-segment display with the step count, selector and selected word.

## Interface
- `SCAN_DIV`, 50000: clk cycles per display digit slot (1 kHz digit rate at 50 MHz); minimum 2.
- `DONE_TIMEOUT`, 255: max WAIT cycles before a step is abandoned; 1..255.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle step request, synchronous to `clk`.
- `key_v` in 3: debug view selector.
- `cpu_done` in 1: CPU step-complete pulse/level.
- `dbg_word` in 16: CPU debug word addressed by `dbg_sel`.
- `cpu_step` out 1: one-cycle CPU step enable.
- `dbg_sel` out 3: registered copy of `key_v` to CPU debug mux.
- `busy` out 1: high while a step is in flight.
- `seg` out 8: active-low segments, `seg[7]`=dp, `seg[6:0]`=g..a.
- `an` out 8: active-low one-hot digit enable.

## Operation
- Reset values: `cpu_step`=0, `busy`=0, `dbg_sel`=0, `seg`=8'hFF, `an`=8'hFF, step count=0, shown word=0, err=0, FSM=IDLE, scan counters=0.
- FSM states IDLE, STEP, WAIT, LATCH:
  - IDLE: `start`=1 -> STEP, err cleared. Shown word <= `dbg_word` every cycle (live view).
  - STEP: `cpu_step`=1 this cycle only; timeout counter cleared; -> WAIT.
  - WAIT: `cpu_done`=1 -> LATCH; else counter increments; counter == DONE_TIMEOUT-1 with no done -> LATCH, err=1.
  - LATCH: shown word <= `dbg_word`; step count +1 (8-bit, 255 wraps to 0); -> IDLE.
- `busy` = (state != IDLE). `start` in any non-IDLE state ignored, not queued.
- `cpu_done` outside WAIT ignored (including STEP cycle).
- `dbg_sel` <= `key_v` every cycle, independent of FSM; shown word frozen while busy.
- Display digits (digit 0 rightmost): 3..0 = shown word hex, MS nibble on digit 3; 4 blank; 5 = `{1'b0,dbg_sel}` hex; 7..6 = step count hex (see Configuration). dp lit on digit 0 iff err=1; all other dp off.
- Blank digit: `seg`=8'hFF with `an` still asserted.

## Timing
- `dbg_sel` lags `key_v` by 1 cycle; shown word reflects new selection 2 cycles after `key_v` changes (IDLE).
- `start` at cycle N -> `cpu_step`=1 at N+1 (registered FSM output), `busy`=1 from N+1.
- `cpu_done` at WAIT cycle M -> LATCH at M+1, `busy`=0 and updated count at M+2.
- Earliest completion: `cpu_done` held high -> start-to-idle 4 cycles; next `start` accepted the cycle `busy` is 0.
- Timeout: WAIT lasts exactly DONE_TIMEOUT cycles.
- Scan: prescaler 0..SCAN_DIV-1; on wrap digit index increments 0..7, wraps to 0. `an`/`seg` registered, change together, same cycle as index update. Full refresh = 8*SCAN_DIV cycles.
- `rst` mid-step: immediate return to reset values; no extra `cpu_step`.

## Configuration
- `STEP_CNT_EN` defined: step counter implemented; digits 7..6 show count.
- Undefined: no step counter register; digits 7..6 blank; FSM and all other behaviour unchanged.

## Structure
- Shared package: FSM state encoding, `SEG_BLANK`=8'hFF, 16-entry hex-to-segment pattern constants, digit index width.
- Sub-module `hex_to_seg7`: combinational 4-bit nibble -> 7-bit active-low segment pattern; instantiated once on the scan-muxed nibble.

## Test plan
- Reset: assert `rst` mid-WAIT -> `cpu_step`=0, `busy`=0, `an`=8'hFF, `seg`=8'hFF, count=0.
- Normal step: `key_v`=3, `dbg_word`=16'hA5C3, `start` pulse, `cpu_done` 3 cycles after `cpu_step` -> exactly one `cpu_step` cycle, `dbg_sel`=3, digits 3..0 = A,5,C,3, count=01.
- Busy reject: second `start` during WAIT -> still one `cpu_step`, count increments by 1 only.
- Timeout: DONE_TIMEOUT=4, no `cpu_done` -> WAIT 4 cycles, err=1, digit 0 dp lit (`seg[7]`=0); next `start` clears err.
- Wrap: 256 completed steps -> count 255 then 00; with `STEP_CNT_EN` undefined digits 7..6 blank throughout.
- Scan: SCAN_DIV=2 -> `an` steps FE,FD,FB,...,7F,FE every 2 cycles; digit 4 `seg`=FF, digit 5 shows `dbg_sel`.
